// File: rtl/ccsds_turbo_dec_sink_bp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ccsds_turbo_dec_sink_bp_pkg : shared types for the backpressure decoder sink
// Rev 1.0
// ----------------------------------------------------------------------------
package ccsds_turbo_dec_sink_bp_pkg;

    localparam int cW = 16;

    typedef logic [cW-1:0] ptab_dat_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ccsds_turbo_dec_sink_bp_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ccsds_turbo_dec_sink_bp_if : RAM-side inputs and downstream stream bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface ccsds_turbo_dec_sink_bp_if
    import ccsds_turbo_dec_sink_bp_pkg::*;
#(
    parameter int pADDR_W = 8,
    parameter int pDAT_W  = 2,
    parameter int pTAG_W  = 8
);
    logic                iclkena;
    ptab_dat_t           iN;
    logic                ifull;
    logic [pDAT_W-1:0]   irdata;
    logic [15:0]         ierr;
    logic [pTAG_W-1:0]   itag;
    logic                orempty;
    logic [pADDR_W-1:0]  oraddr;
    logic                oready;
    logic                ofull;
    logic [pTAG_W-1:0]   otag;
    logic                osop;
    logic                oeop;
    logic                oval;
    logic [pDAT_W-1:0]   odat;
    logic [15:0]         oerr;

    modport slave (
        input  iclkena, iN, ifull, irdata, ierr, itag, oready,
        output orempty, oraddr, ofull, otag, osop, oeop, oval, odat, oerr
    );

    modport master (
        output iclkena, iN, ifull, irdata, ierr, itag, oready,
        input  orempty, oraddr, ofull, otag, osop, oeop, oval, odat, oerr
    );
endinterface
`default_nettype wire

// File: rtl/ccsds_turbo_dec_sink_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ccsds_turbo_dec_sink_fifo : show-ahead skid FIFO with occupancy count
// Rev 1.0
// ----------------------------------------------------------------------------
module ccsds_turbo_dec_sink_fifo #(
    parameter int pW = 3,
    parameter int pD = 4
)(
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        push,
    input  wire logic [pW-1:0]               wdat,
    input  wire logic                        pop,
    output logic      [pW-1:0]               rdat,
    output logic                             empty,
    output logic      [$clog2(pD+1)-1:0]     cnt
);
    localparam int cPTR_W = (pD > 1) ? $clog2(pD) : 1;
    localparam int cCNT_W = $clog2(pD + 1);

    logic [pW-1:0]     r_mem [pD];
    logic [cPTR_W-1:0] r_wptr;
    logic [cPTR_W-1:0] r_rptr;
    logic [cCNT_W-1:0] r_cnt;
    logic              w_wr;
    logic              w_rd;

    assign w_wr = push && (r_cnt != cCNT_W'(pD));
    assign w_rd = pop  && (r_cnt != '0);

    // Storage is left unreset; the head is only meaningful while not empty.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wdat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= (r_wptr == cPTR_W'(pD - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= (r_rptr == cPTR_W'(pD - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign rdat  = r_mem[r_rptr];
    assign empty = (r_cnt == '0);
    assign cnt   = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ccsds_turbo_dec_sink_bp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ccsds_turbo_dec_sink_bp : output-RAM reader with credit-based skid FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module ccsds_turbo_dec_sink_bp
    import ccsds_turbo_dec_sink_bp_pkg::*;
#(
    parameter int pADDR_W = 8,
    parameter int pDAT_W  = 2,
    parameter int pTAG_W  = 8,
    parameter int pRD_LAT = 2
)(
    input  wire logic                  iclk,
    input  wire logic                  ireset,
    ccsds_turbo_dec_sink_bp_if.slave   bus
);
    localparam int cN_LSB  = $clog2(pDAT_W);
    localparam int cFIFO_D = pRD_LAT + 2;
    localparam int cCNT_W  = $clog2(cFIFO_D + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [pADDR_W-1:0]  r_raddr;
    logic [pADDR_W-1:0]  r_last;
    logic                r_ofull;
    logic                r_sop_pend;
    logic [pTAG_W-1:0]   r_tag;
    logic [15:0]         r_err;
    logic [pRD_LAT-1:0]  r_vld_sr;
    logic [pRD_LAT-1:0]  r_eop_sr;

    logic                w_accept;
    logic                w_final;
    logic                w_credit;
    logic                w_issue;
    logic                w_xfer;
    logic                w_push;
    logic                w_empty;
    logic [pDAT_W:0]     w_head;
    logic [pDAT_W-1:0]   w_head_dat;
    logic                w_head_eop;
    logic [cCNT_W-1:0]   w_fifo_cnt;
    int                  w_inflight;

    // Reads still travelling through the RAM pipeline hold a FIFO slot.
    always_comb begin
        w_inflight = 0;
        for (int k = 0; k < pRD_LAT; k++) begin
            w_inflight = w_inflight + int'(r_vld_sr[k]);
        end
    end

    assign w_accept   = bus.iclkena && (r_state == ST_IDLE) && bus.ifull;
    assign w_final    = (r_raddr == r_last);
    assign w_credit   = (int'(w_fifo_cnt) + w_inflight) < cFIFO_D;
    assign w_issue    = bus.iclkena && (r_state == ST_READ) && w_credit;
    assign w_xfer     = bus.iclkena && !w_empty && bus.oready;
    assign w_push     = bus.iclkena && r_vld_sr[pRD_LAT-1];
    assign w_head_dat = w_head[pDAT_W:1];
    assign w_head_eop = w_head[0];

    ccsds_turbo_dec_sink_fifo #(
        .pW (pDAT_W + 1),
        .pD (cFIFO_D)
    ) u_fifo (
        .clk   (iclk),
        .rst   (ireset),
        .push  (w_push),
        .wdat  ({bus.irdata, r_eop_sr[pRD_LAT-1]}),
        .pop   (w_xfer),
        .rdat  (w_head),
        .empty (w_empty),
        .cnt   (w_fifo_cnt)
    );

    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        bus.oval    = !w_empty;
        bus.odat    = w_empty ? '0 : w_head_dat;
        bus.oeop    = !w_empty && w_head_eop;
        bus.osop    = !w_empty && r_sop_pend;
        bus.orempty = w_xfer && w_head_eop;
        case (r_state)
            ST_IDLE:  if (w_accept)              w_state_nxt = ST_READ;
            ST_READ:  if (w_issue && w_final)    w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_xfer && w_head_eop)  w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_raddr    <= '0;
            r_last     <= '0;
            r_ofull    <= 1'b0;
            r_sop_pend <= 1'b0;
            r_tag      <= '0;
            r_err      <= '0;
            r_vld_sr   <= '0;
            r_eop_sr   <= '0;
        end else if (bus.iclkena) begin
            r_vld_sr[0] <= w_issue;
            r_eop_sr[0] <= w_issue && w_final;
            for (int k = 1; k < pRD_LAT; k++) begin
                r_vld_sr[k] <= r_vld_sr[k-1];
                r_eop_sr[k] <= r_eop_sr[k-1];
            end
            if (w_accept) begin
                r_tag      <= bus.itag;
                r_err      <= bus.ierr;
                r_last     <= pADDR_W'((bus.iN >> cN_LSB) - 1'b1);
                r_ofull    <= 1'b1;
                r_raddr    <= '0;
                r_sop_pend <= 1'b1;
            end else begin
                if (w_issue) begin
                    r_raddr <= r_raddr + 1'b1;
                end
                if (w_xfer) begin
                    r_sop_pend <= 1'b0;
                end
                if (w_xfer && w_head_eop) begin
                    r_ofull <= 1'b0;
                end
            end
        end
    end

    assign bus.oraddr = r_raddr;
    assign bus.ofull  = r_ofull;
    assign bus.otag   = r_tag;
    assign bus.oerr   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ccsds_turbo_dec_sink_bp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ccsds_turbo_dec_sink_bp : scoreboard bench for the backpressure sink
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ccsds_turbo_dec_sink_bp;
    import ccsds_turbo_dec_sink_bp_pkg::*;

    localparam int pADDR_W = 8;
    localparam int pDAT_W  = 2;
    localparam int pTAG_W  = 8;
    localparam int pRD_LAT = 2;

    typedef struct {
        logic [pDAT_W-1:0] dat;
        logic              sop;
        logic              eop;
        logic [pTAG_W-1:0] tag;
        logic [15:0]       err;
    } exp_t;

    logic iclk = 1'b0;
    logic ireset;

    ccsds_turbo_dec_sink_bp_if #(
        .pADDR_W (pADDR_W),
        .pDAT_W  (pDAT_W),
        .pTAG_W  (pTAG_W)
    ) bus ();

    ccsds_turbo_dec_sink_bp #(
        .pADDR_W (pADDR_W),
        .pDAT_W  (pDAT_W),
        .pTAG_W  (pTAG_W),
        .pRD_LAT (pRD_LAT)
    ) dut (
        .iclk   (iclk),
        .ireset (ireset),
        .bus    (bus)
    );

    always #5 iclk = ~iclk;

    exp_t               exp_q [$];
    exp_t               e;
    int                 n_cmp = 0;
    int                 n_bad = 0;
    int                 cyc = 0;
    int                 frames_done = 0;
    int                 words_seen = 0;
    int                 n_sop = 0;
    int                 n_eop = 0;
    int                 n_rempty = 0;
    int                 t_sop = -1;
    int                 t_rempty = -1;
    logic               rnd_mode = 1'b0;
    logic               man_oready = 1'b1;
    logic               prev_hold = 1'b0;
    logic [pDAT_W-1:0]  prev_dat = '0;
    logic               prev_eop = 1'b0;
    logic [pADDR_W-1:0] ram_pipe [pRD_LAT];

    always @(posedge iclk) cyc <= cyc + 1;

    // RAM model: data = address, pRD_LAT enabled clocks after the address.
    always @(posedge iclk) begin
        if (bus.iclkena) begin
            ram_pipe[0] <= bus.oraddr;
            for (int k = 1; k < pRD_LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
        end
    end
    assign bus.irdata = ram_pipe[pRD_LAT-1][pDAT_W-1:0];

    always @(posedge iclk) begin
        #2;
        if (rnd_mode) begin
            bus.oready  = 1'($urandom_range(0, 1));
            bus.iclkena = ($urandom_range(0, 7) != 0);
        end else begin
            bus.oready  = man_oready;
            bus.iclkena = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge iclk) begin
        if (ireset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && bus.oval) begin
                chk("hold_dat", 32'(bus.odat), 32'(prev_dat));
                chk("hold_eop", 32'(bus.oeop), 32'(prev_eop));
            end
            if (bus.orempty) begin
                n_rempty++;
                t_rempty = cyc;
            end
            if (bus.iclkena && bus.oval && bus.oready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underrun", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("odat",    32'(bus.odat),    32'(e.dat));
                    chk("osop",    32'(bus.osop),    32'(e.sop));
                    chk("oeop",    32'(bus.oeop),    32'(e.eop));
                    chk("otag",    32'(bus.otag),    32'(e.tag));
                    chk("oerr",    32'(bus.oerr),    32'(e.err));
                    chk("orempty", 32'(bus.orempty), 32'(e.eop));
                    words_seen++;
                    if (e.sop) t_sop = cyc;
                    if (e.eop) frames_done++;
                    if (bus.osop) n_sop++;
                    if (bus.oeop) n_eop++;
                end
            end else begin
                chk("orempty_idle", 32'(bus.orempty), 32'd0);
            end
            prev_hold = bus.oval && !(bus.iclkena && bus.oready);
            prev_dat  = bus.odat;
            prev_eop  = bus.oeop;
        end
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic push_exp(input int n, input logic [pTAG_W-1:0] tag, input logic [15:0] err);
        int words = n >> 1;
        for (int k = 0; k < words; k++) begin
            exp_t x;
            x.dat = pDAT_W'(k);
            x.sop = (k == 0);
            x.eop = (k == words - 1);
            x.tag = tag;
            x.err = err;
            exp_q.push_back(x);
        end
    endtask

    // Holds ifull until ofull shows acceptance; c_acc is the sampling cycle.
    task automatic start_frame(input int n, input logic [pTAG_W-1:0] tag, input logic [15:0] err,
                               input bit keep, output int c_acc);
        int c_try;
        bit got = 1'b0;
        push_exp(n, tag, err);
        bus.iN    = ptab_dat_t'(n);
        bus.itag  = tag;
        bus.ierr  = err;
        bus.ifull = 1'b1;
        c_acc = -1;
        c_try = cyc;
        for (int i = 0; i < 64 && !got; i++) begin
            tick();
            if (bus.ofull) begin
                got   = 1'b1;
                c_acc = c_try;
            end else begin
                c_try = cyc;
            end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        if (!keep) bus.ifull = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && frames_done < target; i++) tick();
        chk("frame_done", 32'(frames_done), 32'(target));
    endtask

    task automatic check_zero(input string p);
        chk({p, "_orempty"}, 32'(bus.orempty), 32'd0);
        chk({p, "_ofull"},   32'(bus.ofull),   32'd0);
        chk({p, "_osop"},    32'(bus.osop),    32'd0);
        chk({p, "_oeop"},    32'(bus.oeop),    32'd0);
        chk({p, "_oval"},    32'(bus.oval),    32'd0);
        chk({p, "_oraddr"},  32'(bus.oraddr),  32'd0);
        chk({p, "_odat"},    32'(bus.odat),    32'd0);
        chk({p, "_otag"},    32'(bus.otag),    32'd0);
        chk({p, "_oerr"},    32'(bus.oerr),    32'd0);
    endtask

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int c0;
        int w0;
        int b_sop;
        int b_eop;
        int b_rempty;
        int b_frames;
        ireset   = 1'b1;
        bus.ifull = 1'b0;
        bus.iN   = '0;
        bus.itag = '0;
        bus.ierr = '0;
        bus.iclkena = 1'b1;
        bus.oready  = 1'b1;
        repeat (3) tick();
        ireset = 1'b0;
        check_zero("rst");
        repeat (2) tick();

        // Basic frame: 8 words on cycles 4..11.
        w0 = words_seen;
        start_frame(16, 8'h5A, 16'd3, 1'b0, c0);
        chk("b_raddr0", 32'(bus.oraddr), 32'd0);
        chk("b_ofull",  32'(bus.ofull),  32'd1);
        wait_done(1, 200);
        chk("b_sop_cyc",    32'(t_sop - c0),      32'd4);
        chk("b_rempty_cyc", 32'(t_rempty - c0),   32'd11);
        chk("b_words",      32'(words_seen - w0), 32'd8);
        chk("b_otag",       32'(bus.otag),        32'h5A);
        chk("b_oerr",       32'(bus.oerr),        32'd3);
        chk("b_ofull_clr",  32'(bus.ofull),       32'd0);

        // Single word frame.
        w0 = words_seen;
        start_frame(2, 8'hC3, 16'd1, 1'b0, c0);
        wait_done(2, 200);
        chk("s1_sop_cyc",    32'(t_sop - c0),      32'd4);
        chk("s1_rempty_cyc", 32'(t_rempty - c0),   32'd4);
        chk("s1_words",      32'(words_seen - w0), 32'd1);

        // Stall: oready low on cycles 5..12, read address must freeze at 5.
        w0 = words_seen;
        start_frame(16, 8'h21, 16'd7, 1'b0, c0);
        while (cyc - c0 < 13) begin
            man_oready = !((cyc - c0 >= 5) && (cyc - c0 <= 12));
            if (cyc - c0 == 7)  chk("st_raddr7",  32'(bus.oraddr), 32'd5);
            if (cyc - c0 == 12) chk("st_raddr12", 32'(bus.oraddr), 32'd5);
            tick();
        end
        man_oready = 1'b1;
        wait_done(3, 200);
        chk("st_words", 32'(words_seen - w0), 32'd8);

        // Reset mid-frame while stalled, then a clean frame from address 0.
        man_oready = 1'b0;
        start_frame(16, 8'h33, 16'd5, 1'b0, c0);
        while (cyc - c0 < 6) tick();
        ireset = 1'b1;
        tick();
        ireset = 1'b0;
        check_zero("mrst");
        exp_q.delete();
        man_oready = 1'b1;
        repeat (4) tick();
        w0 = words_seen;
        start_frame(16, 8'h44, 16'h0102, 1'b0, c0);
        wait_done(4, 200);
        chk("mrst_words", 32'(words_seen - w0), 32'd8);

        // Back-to-back with ifull held high.
        w0 = words_seen;
        start_frame(8, 8'h11, 16'hAAAA, 1'b1, c0);
        bus.itag = 8'h22;
        bus.ierr = 16'hBBBB;
        bus.iN   = ptab_dat_t'(8);
        push_exp(8, 8'h22, 16'hBBBB);
        wait_done(5, 200);
        chk("bb_gap_ofull", 32'(bus.ofull), 32'd0);
        tick();
        chk("bb_ofull",  32'(bus.ofull),  32'd1);
        chk("bb_otag",   32'(bus.otag),   32'h22);
        chk("bb_oerr",   32'(bus.oerr),   32'hBBBB);
        chk("bb_raddr0", 32'(bus.oraddr), 32'd0);
        bus.ifull = 1'b0;
        wait_done(6, 200);
        chk("bb_words", 32'(words_seen - w0), 32'd8);

        // Random oready / clock enable over 100 frames.
        b_sop = n_sop;
        b_eop = n_eop;
        b_rempty = n_rempty;
        b_frames = frames_done;
        rnd_mode = 1'b1;
        for (int f = 0; f < 100; f++) begin
            start_frame(int'($urandom_range(4, 512)), 8'($urandom), 16'($urandom), 1'b0, c0);
            wait_done(b_frames + f + 1, 3000);
        end
        rnd_mode = 1'b0;
        repeat (3) tick();
        chk("rnd_sop_cnt",    32'(n_sop - b_sop),       32'd100);
        chk("rnd_eop_cnt",    32'(n_eop - b_eop),       32'd100);
        chk("rnd_rempty_cnt", 32'(n_rempty - b_rempty), 32'd100);
        chk("rnd_sb_empty",   32'(exp_q.size()),        32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
